// File: rtl/dpu_seq_pkg.sv
// ============================================================================
// Module      : dpu_seq_pkg
// Description : Shared types, opcodes and widths for the DPU mode sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dpu_seq_pkg;

    localparam int NUM_SLOTS   = 4;
    localparam int MODE_WIDTH  = 5;
    localparam int IMM_WIDTH   = 16;
    localparam int DELAY_WIDTH = 7;
    localparam int INSTR_WIDTH = 27;

    localparam logic [2:0] OPCODE_DPU = 3'd3;
    localparam logic [2:0] OPCODE_FSM = 3'd2;
    localparam int         OPCODE_H   = 26;
    localparam int         OPCODE_L   = 24;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [1:0]            option;
        logic [MODE_WIDTH-1:0] mode;
        logic [IMM_WIDTH-1:0]  imm;
        logic                  pad;
    } dpu_t;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [1:0]             port;
        logic [DELAY_WIDTH-1:0] delay_0;
        logic [DELAY_WIDTH-1:0] delay_1;
        logic [DELAY_WIDTH-1:0] delay_2;
        logic                   pad;
    } fsm_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic dpu_t unpack_dpu(input logic [INSTR_WIDTH-1:0] raw);
        return dpu_t'(raw);
    endfunction

    function automatic fsm_t unpack_fsm(input logic [INSTR_WIDTH-1:0] raw);
        return fsm_t'(raw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpu_seq_timer.sv
// ============================================================================
// Module      : dpu_seq_timer
// Description : Loadable down-counter that holds at zero and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpu_seq_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/dpu_sequencer.sv
// ============================================================================
// Module      : dpu_sequencer
// Description : Instruction-programmed sequencer stepping the DPU through up
//               to four mode/immediate slots with per-slot dwell times.
//               Optional macro DPU_SEQ_LOOP_EN: wrap to slot 0 while activate
//               is held at the end of the last slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpu_sequencer #(
    parameter int NUM_SLOTS   = dpu_seq_pkg::NUM_SLOTS,
    parameter int MODE_WIDTH  = dpu_seq_pkg::MODE_WIDTH,
    parameter int IMM_WIDTH   = dpu_seq_pkg::IMM_WIDTH,
    parameter int DELAY_WIDTH = dpu_seq_pkg::DELAY_WIDTH,
    parameter int INSTR_WIDTH = dpu_seq_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_en,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   activate,
    output logic [MODE_WIDTH-1:0]  mode_out,
    output logic [IMM_WIDTH-1:0]   immediate_out,
    output logic [1:0]             slot_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    import dpu_seq_pkg::*;

    dpu_t   w_dpu;
    fsm_t   w_fsm;
    logic   w_dpu_wr;
    logic   w_fsm_wr;
    logic   w_unused;

    state_t r_state;
    state_t w_state_nxt;
    logic [1:0] r_slot;
    logic [1:0] w_slot_nxt;
    logic [1:0] r_last_slot;
    logic       r_done;
    logic       w_done_nxt;
    logic       r_err;
    logic       w_err_nxt;

    logic [DELAY_WIDTH-1:0] r_delay   [0:2];
    logic [DELAY_WIDTH-1:0] w_delay   [NUM_SLOTS];
    logic [MODE_WIDTH-1:0]  r_slot_mode [NUM_SLOTS];
    logic [IMM_WIDTH-1:0]   r_slot_imm  [NUM_SLOTS];

    logic                   w_load;
    logic [DELAY_WIDTH-1:0] w_load_val;
    logic                   w_zero;

    assign w_dpu    = unpack_dpu(instr);
    assign w_fsm    = unpack_fsm(instr);
    assign w_dpu_wr = instr_en && (instr[OPCODE_H:OPCODE_L] == OPCODE_DPU);
    assign w_fsm_wr = instr_en && (instr[OPCODE_H:OPCODE_L] == OPCODE_FSM);
    assign w_unused = ^{w_dpu.opcode, w_dpu.pad, w_fsm.opcode, w_fsm.pad};

    // The last slot has no programmable dwell; it always lasts one cycle.
    assign w_delay[0] = r_delay[0];
    assign w_delay[1] = r_delay[1];
    assign w_delay[2] = r_delay[2];
    assign w_delay[3] = '0;

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = w_fsm_wr && (r_state == RUN);
        case (r_state)
            IDLE: begin
                if (activate) begin
                    w_state_nxt = RUN;
                    w_slot_nxt  = 2'd0;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (w_zero) begin
                    if (r_slot < r_last_slot) begin
                        w_slot_nxt = r_slot + 2'd1;
                        w_load     = 1'b1;
                    end else begin
`ifdef DPU_SEQ_LOOP_EN
                        if (activate) begin
                            w_slot_nxt = 2'd0;
                            w_load     = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                            w_slot_nxt  = 2'd0;
                            w_done_nxt  = 1'b1;
                        end
`else
                        w_state_nxt = IDLE;
                        w_slot_nxt  = 2'd0;
                        w_done_nxt  = 1'b1;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_slot_nxt  = 2'd0;
            end
        endcase
        w_load_val = w_delay[w_slot_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_slot  <= 2'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Sequence configuration is frozen while a run is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_slot <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_delay[i] <= '0;
            end
        end else if (w_fsm_wr && (r_state == IDLE)) begin
            r_last_slot <= w_fsm.port;
            r_delay[0]  <= w_fsm.delay_0;
            r_delay[1]  <= w_fsm.delay_1;
            r_delay[2]  <= w_fsm.delay_2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slot_mode[i] <= '0;
                r_slot_imm[i]  <= '0;
            end
        end else if (w_dpu_wr) begin
            r_slot_mode[w_dpu.option] <= w_dpu.mode;
            r_slot_imm[w_dpu.option]  <= w_dpu.imm;
        end
    end

    dpu_seq_timer #(
        .WIDTH (DELAY_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    assign busy          = (r_state == RUN);
    assign mode_out      = busy ? r_slot_mode[r_slot] : '0;
    assign immediate_out = busy ? r_slot_imm[r_slot]  : '0;
    assign slot_out      = busy ? r_slot : 2'd0;
    assign done          = r_done;
    assign err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dpu_sequencer.sv
// ============================================================================
// Module      : tb_dpu_sequencer
// Description : Self-checking bench for dpu_sequencer against a slot-list model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_en;
    logic [26:0] instr;
    logic        activate;
    logic [4:0]  mode_out;
    logic [15:0] immediate_out;
    logic [1:0]  slot_out;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    int m_mode  [4];
    int m_imm   [4];
    int m_delay [3];
    int m_last;

    dpu_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .instr_en      (instr_en),
        .instr         (instr),
        .activate      (activate),
        .mode_out      (mode_out),
        .immediate_out (immediate_out),
        .slot_out      (slot_out),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] enc_dpu(input int opt, input int mode, input int imm);
        return {3'd3, 2'(opt), 5'(mode), 16'(imm), 1'b0};
    endfunction

    function automatic logic [26:0] enc_fsm(input int last, input int d0, input int d1, input int d2);
        return {3'd2, 2'(last), 7'(d0), 7'(d1), 7'(d2), 1'b0};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = 0;
            m_imm[i]  = 0;
        end
        for (int i = 0; i < 3; i++) m_delay[i] = 0;
        m_last = 0;
    endtask

    // All tasks start and end one time unit after a rising edge.
    task automatic write_dpu(input int opt, input int mode, input int imm);
        instr = enc_dpu(opt, mode, imm);
        instr_en = 1'b1;
        @(posedge clk); #1;
        instr_en = 1'b0;
        m_mode[opt] = mode;
        m_imm[opt]  = imm;
    endtask

    task automatic write_fsm(input int last, input int d0, input int d1, input int d2);
        instr = enc_fsm(last, d0, d1, d2);
        instr_en = 1'b1;
        @(posedge clk); #1;
        instr_en = 1'b0;
        m_last = last;
        m_delay[0] = d0;
        m_delay[1] = d1;
        m_delay[2] = d2;
    endtask

    task automatic write_junk();
        logic [2:0] op;
        op = 3'($urandom_range(4, 7));
        if ($urandom_range(0, 1) == 1) op = 3'($urandom_range(0, 1));
        instr = {op, 24'($urandom)};
        instr_en = 1'b1;
        @(posedge clk); #1;
        instr_en = 1'b0;
    endtask

    // kind: 0 none, 1 FSM write mid-run (rejected), 2 DPU write to running slot.
    task automatic run_seq(input int kind, input int at, input int new_mode);
        int q[$];
        int inj;
        logic exp_err;
        for (int k = 0; k <= m_last; k++) begin
            int d;
            d = (k == 3) ? 0 : m_delay[k];
            for (int c = 0; c <= d; c++) q.push_back(k);
        end
        inj = (kind == 0) ? -1 : ((at < 0) ? int'($urandom_range(0, q.size() - 1)) : at);
        exp_err = 1'b0;
        activate = 1'b1;
        @(posedge clk); #1;
        activate = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            chk("run_busy", busy, 1);
            chk("run_slot", slot_out, q[i]);
            chk("run_mode", mode_out, m_mode[q[i]]);
            chk("run_imm",  immediate_out, m_imm[q[i]]);
            chk("run_done", done, 0);
            chk("run_err",  err, exp_err);
            exp_err = 1'b0;
            activate = (i < q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == inj) begin
                instr = (kind == 1) ? enc_fsm($urandom_range(0, 3), $urandom_range(0, 9),
                                              $urandom_range(0, 9), $urandom_range(0, 9))
                                    : enc_dpu(q[i], new_mode, m_imm[q[i]]);
                instr_en = 1'b1;
            end
            @(posedge clk); #1;
            if (i == inj) begin
                instr_en = 1'b0;
                if (kind == 1) exp_err = 1'b1;
                else m_mode[q[i]] = new_mode;
            end
        end
        activate = 1'b0;
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("end_mode", mode_out, 0);
        chk("end_imm",  immediate_out, 0);
        chk("end_slot", slot_out, 0);
        chk("end_err",  err, exp_err);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_err",  err, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst      = 1'b1;
        instr_en = 1'b0;
        instr    = '0;
        activate = 1'b0;
        model_clear();
        #12;
        chk("rst_mode", mode_out, 0);
        chk("rst_imm",  immediate_out, 0);
        chk("rst_slot", slot_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic two-slot run: mode 1 for three cycles, then mode 7 for one.
        write_dpu(0, 1, 16'h0010);
        write_dpu(1, 7, 16'h0020);
        write_fsm(1, 2, 0, 0);
        run_seq(0, -1, 0);

        // Four slots, single-cycle dwell each.
        write_dpu(2, 3, 16'h0300);
        write_dpu(3, 4, 16'h0400);
        write_fsm(3, 0, 0, 0);
        run_seq(0, -1, 0);

        // Rejected FSM write mid-run; next run must use the unchanged delays.
        write_fsm(2, 1, 2, 1);
        run_seq(1, 2, 0);
        run_seq(0, -1, 0);

        // Live update of the running slot's mode.
        write_dpu(0, 1, 16'h00aa);
        write_fsm(0, 3, 0, 0);
        run_seq(2, 0, 10);

        // Randomized programs with junk opcodes and mid-run injections.
        for (int r = 0; r < 10; r++) begin
            for (int s = 0; s < 4; s++) begin
                write_dpu(s, $urandom_range(0, 31), $urandom_range(0, 65535));
            end
            write_junk();
            write_fsm($urandom_range(0, 3), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 4));
            write_junk();
            run_seq($urandom_range(0, 2), -1, $urandom_range(0, 31));
        end

`ifdef DPU_SEQ_LOOP_EN
        write_dpu(0, 2, 16'h0202);
        write_dpu(1, 3, 16'h0303);
        write_fsm(1, 0, 0, 0);
        activate = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("loop_slot", slot_out, i % 2);
            chk("loop_mode", mode_out, m_mode[i % 2]);
            chk("loop_busy", busy, 1);
            chk("loop_done", done, 0);
            if (i == 5) activate = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("loop_end_done", done, 1);
        chk("loop_end_busy", busy, 0);
        @(posedge clk); #1;
`endif

        // Asynchronous reset during slot 1 aborts the run and clears memories.
        write_dpu(0, 4, 16'h0044);
        write_dpu(1, 9, 16'h0099);
        write_fsm(1, 1, 3, 0);
        activate = 1'b1;
        @(posedge clk); #1;
        activate = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_slot", slot_out, 1);
        chk("pre_rst_mode", mode_out, 9);
        #1 rst = 1'b1;
        #1;
        chk("arst_mode", mode_out, 0);
        chk("arst_imm",  immediate_out, 0);
        chk("arst_slot", slot_out, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("arst_no_done", done, 0);
            chk("arst_idle", busy, 0);
        end
        @(posedge clk); #1;
        run_seq(0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire

// File: doc/dpu_sequencer.md
# dpu_sequencer

Instruction-programmed controller that sequences the complex DPU through up to four mode slots. It decodes the DPU and FSM resource instructions, stores a mode/immediate pair per slot and a dwell time per slot, and on `activate` steps through the slots, presenting the current mode and immediate to the datapath. It sits between the resource instruction bus and the DPU datapath's mode/immediate inputs and replaces the ad-hoc slot FSM inside the DPU.

## Interface
- `NUM_SLOTS`, 4: number of mode slots; fixed by the 2-bit option field.
- `MODE_WIDTH`, 5: DPU mode field width.
- `IMM_WIDTH`, 16: DPU immediate field width.
- `DELAY_WIDTH`, 7: per-slot dwell field width.
- `INSTR_WIDTH`, 27: resource instruction width.

Ports:
- `clk` in 1: the block's one clock.
- `rst` in 1: reset, asynchronous, active-high.
- `instr_en` in 1: `instr` valid this cycle.
- `instr` in `INSTR_WIDTH`: resource instruction.
- `activate` in 1: start request; level-sampled.
- `mode_out` out `MODE_WIDTH`: mode for the datapath.
- `immediate_out` out `IMM_WIDTH`: immediate for the datapath.
- `slot_out` out 2: current slot index.
- `busy` out 1: a sequence is running.
- `done` out 1: one-cycle pulse when a sequence completes.
- `err` out 1: one-cycle pulse when an FSM instruction is rejected.

## Operation
- Decode: `opcode = instr[26:24]`, accepted only when `instr_en`=1. Other opcodes are ignored.
- DPU instruction (opcode 3): `option = [23:22]`, `mode = [21:17]`, `imm = [16:1]`.
  - Writes `slot_mode[option]` and `slot_imm[option]`.
  - Accepted in any state.
  - The write is visible on the outputs from the next cycle, including when it targets the running slot.
- FSM instruction (opcode 2): `port = [23:22]` sets `last_slot`; `delay_0 = [21:15]`, `delay_1 = [14:8]`, `delay_2 = [7:1]`.
  - Writes `last_slot` and `delay[0..2]`.
  - `delay[3]` is hardwired to 0.
  - Accepted only in IDLE. In RUN it is discarded and `err` pulses the next cycle.
- States: IDLE and RUN.
  - IDLE → RUN when `activate`=1 at a clock edge. On entry, slot=0 and counter=`delay[0]`.
  - In RUN, while counter≠0: counter decrements by 1.
  - In RUN, when counter=0 and slot<`last_slot`: slot increments and counter loads `delay[slot+1]`.
  - In RUN, when counter=0 and slot=`last_slot`: go to IDLE and pulse `done` in the first IDLE cycle.
  - `activate` during RUN is ignored. A sequence is never restarted mid-run.
- Dwell and run length:
  - Slot k is presented for `delay[k]`+1 cycles.
  - Total RUN cycles = Σ(`delay[k]`+1) for k=0..`last_slot`.
  - The counter is unsigned `DELAY_WIDTH`; no wrap occurs because it is only loaded at 0.
- Outputs:
  - In RUN: `mode_out`=`slot_mode[slot]`, `immediate_out`=`slot_imm[slot]`, `slot_out`=slot.
  - In IDLE: `mode_out`, `immediate_out` and `slot_out` are 0 (mode 0 is the DPU no-op).
- Simultaneous events:
  - `activate`=1 in the `done` cycle starts a new run at the next edge.
  - An FSM instruction in the same cycle as an IDLE→RUN transition is accepted, because the state is IDLE at that edge. The new delays apply from the following slot load; `delay[0]` for this run is the old value.

## Timing
- Reset values: all outputs 0, state IDLE, all slot memories 0, all delays 0, `last_slot`=0, counter 0.
- Reset asserted mid-run aborts the run immediately. No `done` pulse is produced.
- `activate` at edge N gives `busy`=1 and slot 0 on the outputs from cycle N+1.
- `mode_out` and `immediate_out` are combinational from the registered slot index and slot memory, so they have zero added latency.
- `done` and `err` are registered and last exactly one cycle.
- `busy` is registered and equals (state==RUN).

## Configuration
- `DPU_SEQ_LOOP_EN` defined: at the final dwell cycle of `last_slot`, if `activate`=1 the sequencer wraps to slot 0 and loads `delay[0]`.
  - It stays in RUN with no `done` pulse.
  - If `activate`=0, it completes normally.
- Not defined: every run ends in IDLE with `done`. `activate` is only sampled in IDLE.

## Structure
- Package `dpu_seq_pkg` contains:
  - `dpu_t` and `fsm_t` packed instruction structs, with their unpack functions;
  - `OPCODE_DPU`=3, `OPCODE_FSM`=2, `OPCODE_H`=26, `OPCODE_L`=24;
  - the width constants;
  - the state enum {IDLE, RUN}.
- Sub-module `dpu_seq_timer`: loadable down-counter (`load`, `load_val`, `zero` flag). The top level contains the decode, the slot memories and the FSM.

## Test plan
- DPU writes slot0=(mode 1, imm 0x0010) and slot1=(mode 7, imm 0x0020); FSM writes `last_slot`=1, `delay_0`=2, `delay_1`=0; then pulse `activate` → `mode_out` is 1 for 3 cycles, then 7 for 1 cycle, then 0. `done` pulses once and `busy` is high for exactly 4 cycles.
- `last_slot`=3 with all delays 0 → slots 0,1,2,3 for one cycle each. `busy` is high for 4 cycles, then `done`.
- FSM instruction issued during RUN → `err` pulses one cycle later. The running sequence timing is unchanged, and the delays read back unchanged on the next run.
- DPU write to the currently running slot changing mode 1→10 → `mode_out` shows 10 from the next cycle, within the same dwell.
- `rst` asserted during slot 1 → all outputs are 0 immediately and no `done` pulse follows. After reset is released, `activate` gives `mode_out`=0, because the memories were cleared.
- With `DPU_SEQ_LOOP_EN` and `activate` held high, `last_slot`=1, delays 0 → slot pattern 0,1,0,1… with no `done`. Drop `activate` → `done` follows the next slot-1 cycle.
